// File: rtl/unidade_de_busca.sv
// unidade_de_busca: instruction fetch stage with PC, req/ack memory port and FWFT prefetch FIFO.
// Latency: first mem_req one edge after reset release; with mem_ack=1, data valid one edge after request.
// Backpressure: requests issued only while FIFO has room for the in-flight word; inst_pronta pops head.
// Optional macro BUSCA_ERRO_ALINHAMENTO_EN: misaligned redirect target raises sticky
// erro_alinhamento and halts fetching; undefined, alvo[1:0] is silently zeroed.
module unidade_de_busca #(
  parameter int unsigned PROFUNDIDADE = 4,
  parameter logic [31:0] PC_RESET     = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_end,
  input  logic        mem_ack,
  input  logic [31:0] mem_dado,
  output logic        inst_valida,
  output logic [31:0] instrucao,
  output logic [31:0] pc_inst,
  input  logic        inst_pronta,
  input  logic        redireciona,
  input  logic [31:0] alvo
`ifdef BUSCA_ERRO_ALINHAMENTO_EN
  ,
  output logic        erro_alinhamento
`endif
);

  localparam int AW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam logic [AW:0] LP_PROF = (AW+1)'(PROFUNDIDADE);

  typedef enum logic [1:0] {
    ST_BUSCA    = 2'd0,
    ST_DESCARTA = 2'd1,
    ST_ERRO     = 2'd2
  } estado_t;

  estado_t     r_state;
  estado_t     w_state_next;
  logic        r_mem_req;
  logic [31:0] r_mem_end;
  logic [31:0] r_alvo;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [31:0] r_fifo_pc   [PROFUNDIDADE];
  logic [31:0] r_fifo_inst [PROFUNDIDADE];

  logic        w_xfer;
  logic        w_pendente_fica;
  logic        w_vazia;
  logic        w_pop;
  logic        w_push;
  logic        w_flush;
  logic        w_desalinhado;
  logic        w_req_next;
  logic [31:0] w_end_next;
  logic [31:0] w_alvo_next;
  logic [31:0] w_alvo_al;
  logic [AW:0] w_cnt;
  logic [AW:0] w_cnt_next;

  assign w_xfer          = r_mem_req & mem_ack;
  assign w_pendente_fica = r_mem_req & ~mem_ack;
  assign w_alvo_al       = alvo & 32'hFFFF_FFFC;
  assign w_vazia         = (r_wr_ptr == r_rd_ptr);
  assign w_cnt           = r_wr_ptr - r_rd_ptr;
  assign w_flush         = redireciona;
  // A pop coinciding with a redirect is meaningless: the FIFO is being cleared anyway.
  assign w_pop           = ~w_vazia & inst_pronta & ~redireciona;

`ifdef BUSCA_ERRO_ALINHAMENTO_EN
  assign w_desalinhado = redireciona & (alvo[1:0] != 2'b00);
`else
  assign w_desalinhado = 1'b0;
`endif

  // Next state, next fetch address, latched target and push decision.
  always_comb begin
    w_state_next = r_state;
    w_end_next   = r_mem_end;
    w_alvo_next  = r_alvo;
    w_push       = 1'b0;
    case (r_state)
      ST_BUSCA: begin
        if (w_desalinhado) begin
          w_state_next = ST_ERRO;
        end else if (redireciona) begin
          // A request that is still waiting must finish at its old address first.
          if (w_pendente_fica) begin
            w_state_next = ST_DESCARTA;
            w_alvo_next  = w_alvo_al;
          end else begin
            w_end_next = w_alvo_al;
          end
        end else if (w_xfer) begin
          w_push     = 1'b1;
          w_end_next = r_mem_end + 32'd4;
        end
      end
      ST_DESCARTA: begin
        if (w_desalinhado) begin
          w_state_next = ST_ERRO;
        end else begin
          if (redireciona) w_alvo_next = w_alvo_al;
          if (w_xfer) begin
            w_state_next = ST_BUSCA;
            w_end_next   = redireciona ? w_alvo_al : r_alvo;
          end
        end
      end
      ST_ERRO: begin
        w_state_next = ST_ERRO;
      end
      default: begin
        w_state_next = ST_BUSCA;
      end
    endcase
  end

  // Occupancy after this edge and the request-issue decision that depends on it.
  always_comb begin
    w_cnt_next = w_flush ? '0
                         : (w_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop});
    w_req_next = 1'b0;
    if (w_state_next == ST_ERRO) begin
      w_req_next = w_pendente_fica;
    end else if (w_pendente_fica) begin
      w_req_next = 1'b1;
    end else begin
      w_req_next = (w_cnt_next < LP_PROF);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BUSCA;
    else        r_state <= w_state_next;
  end

  // Fetch request, address and pending redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req <= 1'b0;
      r_mem_end <= PC_RESET;
      r_alvo    <= '0;
    end else begin
      r_mem_req <= w_req_next;
      r_mem_end <= w_end_next;
      r_alvo    <= w_alvo_next;
    end
  end

  // FIFO pointers; a flush empties the FIFO by catching the read pointer up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are only observable through a non-empty head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr[AW-1:0]]   <= r_mem_end;
      r_fifo_inst[r_wr_ptr[AW-1:0]] <= mem_dado;
    end
  end

`ifdef BUSCA_ERRO_ALINHAMENTO_EN
  logic r_erro;
  // Sticky alignment error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_erro <= 1'b0;
    else if (w_state_next == ST_ERRO)  r_erro <= 1'b1;
  end
  assign erro_alinhamento = r_erro;
`endif

  assign mem_req     = r_mem_req;
  assign mem_end     = r_mem_end;
  assign inst_valida = ~w_vazia;
  assign instrucao   = w_vazia ? 32'h0 : r_fifo_inst[r_rd_ptr[AW-1:0]];
  assign pc_inst     = w_vazia ? 32'h0 : r_fifo_pc[r_rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_unidade_de_busca.sv
// Testbench for unidade_de_busca: directed steps with hand-computed expectations.
// Memory model: word at byte address A is 32'h13 + A/4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_unidade_de_busca;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_end;
  logic        mem_ack;
  logic [31:0] mem_dado;
  logic        inst_valida;
  logic [31:0] instrucao;
  logic [31:0] pc_inst;
  logic        inst_pronta;
  logic        redireciona;
  logic [31:0] alvo;

  int checks;
  int errors;

  unidade_de_busca #(.PROFUNDIDADE(4), .PC_RESET(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_end     (mem_end),
    .mem_ack     (mem_ack),
    .mem_dado    (mem_dado),
    .inst_valida (inst_valida),
    .instrucao   (instrucao),
    .pc_inst     (pc_inst),
    .inst_pronta (inst_pronta),
    .redireciona (redireciona),
    .alvo        (alvo)
  );

  assign mem_dado = 32'h13 + (mem_end >> 2);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   {31'h0, mem_req},     32'h0);
    chk({tag, "_end"},   mem_end,              32'h0);
    chk({tag, "_vld"},   {31'h0, inst_valida}, 32'h0);
    chk({tag, "_inst"},  instrucao,            32'h0);
    chk({tag, "_pc"},    pc_inst,              32'h0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_vld"},  {31'h0, inst_valida}, 32'h1);
    chk({tag, "_pc"},   pc_inst,              pc);
    chk({tag, "_inst"}, instrucao,            32'h13 + (pc >> 2));
  endtask

  initial begin
    logic [31:0] e;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    mem_ack     = 1'b1;
    inst_pronta = 1'b1;
    redireciona = 1'b0;
    alvo        = 32'h0;

    // Reset state and streaming at one instruction per cycle.
    #2;
    chk_reset("rst0");
    step();
    rst_n = 1'b1;
    step();
    chk("s1_e1_req", {31'h0, mem_req}, 32'h1);
    chk("s1_e1_end", mem_end, 32'h0);
    chk("s1_e1_vld", {31'h0, inst_valida}, 32'h0);
    step();
    chk_head("s1_e2", 32'h0);
    chk("s1_e2_end", mem_end, 32'h4);
    step();
    chk_head("s1_e3", 32'h4);
    step();
    chk_head("s1_e4", 32'h8);
    chk("s1_e4_end", mem_end, 32'hC);

    // Asynchronous reset while requests are flowing.
    rst_n = 1'b0;
    #1;
    chk_reset("rst1");

    // FIFO fills to four entries with the consumer stalled.
    inst_pronta = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step(); step(); step();
    chk("s2_e4_req", {31'h0, mem_req}, 32'h1);
    step();
    chk("s2_full_req", {31'h0, mem_req}, 32'h0);
    chk("s2_full_end", mem_end, 32'h10);
    chk_head("s2_full", 32'h0);
    step(); step();
    chk("s2_hold_req", {31'h0, mem_req}, 32'h0);
    chk("s2_hold_end", mem_end, 32'h10);
    chk_head("s2_hold", 32'h0);
    inst_pronta = 1'b1;
    step();
    inst_pronta = 1'b0;
    chk_head("s2_pop", 32'h4);
    chk("s2_pop_req", {31'h0, mem_req}, 32'h1);
    chk("s2_pop_end", mem_end, 32'h10);
    step();
    chk("s2_refill_req", {31'h0, mem_req}, 32'h0);
    chk("s2_refill_end", mem_end, 32'h14);
    chk_head("s2_refill", 32'h4);

    // Redirect with ack on the same edge as a pop; FIFO holds PC 0,4,8.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step(); step(); step();
    chk_head("s4_pre", 32'h0);
    chk("s4_pre_end", mem_end, 32'hC);
    redireciona = 1'b1;
    alvo        = 32'h40;
    inst_pronta = 1'b1;
    step();
    redireciona = 1'b0;
    inst_pronta = 1'b0;
    chk("s4_flush_vld", {31'h0, inst_valida}, 32'h0);
    chk("s4_flush_req", {31'h0, mem_req}, 32'h1);
    chk("s4_flush_end", mem_end, 32'h40);
    step();
    chk_head("s4_tgt", 32'h40);
    chk("s4_tgt_end", mem_end, 32'h44);

    // Redirect while a request is stalled, then a newer redirect (misaligned bits zeroed).
    mem_ack     = 1'b0;
    inst_pronta = 1'b1;
    step();
    chk("s5_pend_vld", {31'h0, inst_valida}, 32'h0);
    chk("s5_pend_req", {31'h0, mem_req}, 32'h1);
    redireciona = 1'b1;
    alvo        = 32'h80;
    step();
    alvo        = 32'hC3;
    chk("s5_desc_req", {31'h0, mem_req}, 32'h1);
    chk("s5_desc_end", mem_end, 32'h44);
    step();
    redireciona = 1'b0;
    chk("s5_desc2_end", mem_end, 32'h44);
    chk("s5_desc2_vld", {31'h0, inst_valida}, 32'h0);
    mem_ack = 1'b1;
    step();
    chk("s5_drop_vld", {31'h0, inst_valida}, 32'h0);
    chk("s5_drop_req", {31'h0, mem_req}, 32'h1);
    chk("s5_drop_end", mem_end, 32'hC0);
    step();
    chk_head("s5_tgt", 32'hC0);

    // Memory answers three cycles late for each request.
    mem_ack = 1'b0;
    for (int r = 0; r < 3; r++) begin
      e = 32'hC4 + 32'(4 * r);
      for (int w = 0; w < 3; w++) begin
        step();
        chk($sformatf("s3_r%0d_w%0d_req", r, w), {31'h0, mem_req}, 32'h1);
        chk($sformatf("s3_r%0d_w%0d_end", r, w), mem_end, e);
        chk($sformatf("s3_r%0d_w%0d_vld", r, w), {31'h0, inst_valida}, 32'h0);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk_head($sformatf("s3_r%0d_got", r), e);
      chk($sformatf("s3_r%0d_next", r), mem_end, e + 32'h4);
    end

    // Reset during a stalled request, then fetch restarts at PC_RESET.
    step();
    chk("s6_pre_req", {31'h0, mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset("rst2");
    mem_ack = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("s6_e1_req", {31'h0, mem_req}, 32'h1);
    chk("s6_e1_end", mem_end, 32'h0);
    step();
    chk_head("s6_e2", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
